// File: rtl/rgb_pwm_sequencer.sv
// ---------------------------------------------------------------------------
// rgb_pwm_sequencer
//   Multi-channel PWM dimmer for active-low LED pins. Each channel's duty is
//   latched once per PWM period from one of four sources (OFF, STATIC duty
//   input, BLINK pattern from a slow sequencer counter, BREATHE triangle
//   ramp), so control changes never glitch a running period.
//
// Ports
//   clk           in   1                 system clock
//   rst_n         in   1                 asynchronous active-low reset
//   en            in   1                 0: LEDs off, all counters cleared
//   mode          in   2                 0 OFF, 1 STATIC, 2 BLINK, 3 BREATHE
//   duty          in   NUM_CH*PWM_BITS   channel ch = duty[ch*PWM_BITS +: PWM_BITS]
//   led_n         out  NUM_CH            active-low LED drive (registered)
//   period_start  out  1                 pulse on the first output cycle of each period
// ---------------------------------------------------------------------------
module rgb_pwm_sequencer #(
    parameter int NUM_CH    = 3,
    parameter int PWM_BITS  = 8,
    parameter int TICK_DIV  = 187,
    parameter int BLINK_BIT = 6,
    parameter int PHASE_OFS = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [NUM_CH*PWM_BITS-1:0]   duty,
    output logic [NUM_CH-1:0]            led_n,
    output logic                         period_start
);

    localparam int SEQ_BITS   = BLINK_BIT + NUM_CH;
    localparam int PH_BITS    = PWM_BITS + 1;
    localparam int PRESC_BITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PWM_BITS-1:0]   PWM_MAX    = {PWM_BITS{1'b1}};
    localparam logic [PRESC_BITS-1:0] PRESC_LAST = PRESC_BITS'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    // Triangle fold: rising half passes through, falling half is inverted.
    function automatic logic [PWM_BITS-1:0] breathe_level(input logic [PH_BITS-1:0] p);
        logic [PWM_BITS-1:0] lvl;
        if (p[PWM_BITS]) begin
            lvl = ~p[PWM_BITS-1:0];
        end else begin
            lvl = p[PWM_BITS-1:0];
        end
        return lvl;
    endfunction

    logic [PWM_BITS-1:0]                 pwm_cnt_q,  pwm_cnt_d;
    logic [PRESC_BITS-1:0]               presc_q,    presc_d;
    logic [SEQ_BITS-1:0]                 seq_q,      seq_d;
    logic [PH_BITS-1:0]                  phase_q,    phase_d;
    logic [NUM_CH-1:0][PWM_BITS-1:0]     duty_eff_q, duty_eff_d;
    logic                                bnd_q,      bnd_d;
    logic [NUM_CH-1:0]                   led_n_q,    led_n_d;
    logic                                period_start_q, period_start_d;

    logic                                boundary_s;
    logic                                tick_s;
    logic [NUM_CH-1:0][PWM_BITS-1:0]     load_s;

    assign boundary_s = (pwm_cnt_q == PWM_MAX);
    assign tick_s     = (presc_q == PRESC_LAST);

    // Per-channel duty candidate for the next period, from current (pre-tick) seq/phase.
    always_comb begin
        load_s = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            case (mode_e'(mode))
                MODE_OFF: begin
                    load_s[ch] = {PWM_BITS{1'b0}};
                end
                MODE_STATIC: begin
                    load_s[ch] = duty[ch*PWM_BITS +: PWM_BITS];
                end
                MODE_BLINK: begin
                    if (seq_q[BLINK_BIT+ch]) begin
                        load_s[ch] = duty[ch*PWM_BITS +: PWM_BITS];
                    end else begin
                        load_s[ch] = {PWM_BITS{1'b0}};
                    end
                end
                MODE_BREATHE: begin
                    load_s[ch] = breathe_level(phase_q + PH_BITS'(ch * PHASE_OFS));
                end
                default: begin
                    load_s[ch] = {PWM_BITS{1'b0}};
                end
            endcase
        end
    end

    // Next-state for counters, latched duty and output compare.
    always_comb begin
        pwm_cnt_d      = pwm_cnt_q;
        presc_d        = presc_q;
        seq_d          = seq_q;
        phase_d        = phase_q;
        duty_eff_d     = duty_eff_q;
        bnd_d          = 1'b0;
        led_n_d        = {NUM_CH{1'b1}};
        period_start_d = 1'b0;
        if (!en) begin
            pwm_cnt_d  = {PWM_BITS{1'b0}};
            presc_d    = {PRESC_BITS{1'b0}};
            seq_d      = {SEQ_BITS{1'b0}};
            phase_d    = {PH_BITS{1'b0}};
            duty_eff_d = '0;
        end else begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            if (tick_s) begin
                presc_d = {PRESC_BITS{1'b0}};
                seq_d   = seq_q + SEQ_BITS'(1);
                phase_d = phase_q + PH_BITS'(1);
            end else begin
                presc_d = presc_q + PRESC_BITS'(1);
            end
            if (boundary_s) begin
                duty_eff_d = load_s;
            end else begin
                duty_eff_d = duty_eff_q;
            end
            // bnd_q marks "pwm_cnt is 0 and duty_eff is fresh"; delaying the
            // pulse by it lines period_start up with the first led_n sample
            // of the new duty.
            bnd_d          = boundary_s;
            period_start_d = bnd_q;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                led_n_d[ch] = !(pwm_cnt_q < duty_eff_q[ch]);
            end
        end
    end

    // State and output registers; reset forces LEDs off without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q      <= {PWM_BITS{1'b0}};
            presc_q        <= {PRESC_BITS{1'b0}};
            seq_q          <= {SEQ_BITS{1'b0}};
            phase_q        <= {PH_BITS{1'b0}};
            duty_eff_q     <= '0;
            bnd_q          <= 1'b0;
            led_n_q        <= {NUM_CH{1'b1}};
            period_start_q <= 1'b0;
        end else begin
            pwm_cnt_q      <= pwm_cnt_d;
            presc_q        <= presc_d;
            seq_q          <= seq_d;
            phase_q        <= phase_d;
            duty_eff_q     <= duty_eff_d;
            bnd_q          <= bnd_d;
            led_n_q        <= led_n_d;
            period_start_q <= period_start_d;
        end
    end

    assign led_n        = led_n_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Bench for rgb_pwm_sequencer with NUM_CH=3, PWM_BITS=4, TICK_DIV=16,
// BLINK_BIT=0. Instance a uses PHASE_OFS=0, instance b PHASE_OFS=8.
module tb_rgb_pwm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [11:0] duty;
    logic [2:0]  led_a, led_b;
    logic        ps_a, ps_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef logic [2:0][4:0] exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] duty;
        int          chg_at;
        exp_t        e;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    rgb_pwm_sequencer #(.NUM_CH(3), .PWM_BITS(4), .TICK_DIV(16), .BLINK_BIT(0), .PHASE_OFS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .duty(duty),
        .led_n(led_a), .period_start(ps_a));

    rgb_pwm_sequencer #(.NUM_CH(3), .PWM_BITS(4), .TICK_DIV(16), .BLINK_BIT(0), .PHASE_OFS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .duty(duty),
        .led_n(led_b), .period_start(ps_b));

    function automatic exp_t mk(input int e0, input int e1, input int e2);
        exp_t r;
        r[0] = 5'(e0);
        r[1] = 5'(e1);
        r[2] = 5'(e2);
        return r;
    endfunction

    function automatic int tri_lvl(input int p);
        int q;
        q = p % 32;
        return (q < 16) ? q : 31 - q;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits for the first period_start after reset/enable; expects it on
    // sample 17 with LEDs dark before it.
    task automatic wait_first(input string name);
        int n;
        int led_bad;
        n = 0;
        led_bad = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (ps_a) break;
            if (led_a != 3'b111 || led_b != 3'b111 || ps_b) led_bad++;
        end
        check({name, " first period_start sample"}, n, 17);
        check({name, " idle cycles not dark"}, led_bad, 0);
    endtask

    // Checks one full period of both instances. Optionally applies new
    // mode/duty at sample chg_at of this period.
    task automatic run_period(input string name, input bit at_ps, input exp_t ea, input exp_t eb,
                              input int chg_at, input logic [1:0] cmode, input logic [11:0] cduty);
        int waited;
        int ps_bad;
        int low_a [3];
        int low_b [3];
        int bad_a [3];
        int bad_b [3];
        logic expb;
        if (!at_ps) begin
            waited = 0;
            @(negedge clk);
            while (!ps_a && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            if (!ps_a) begin
                check({name, " period_start timeout"}, 0, 1);
                return;
            end
        end
        ps_bad = 0;
        for (int c = 0; c < 3; c++) begin
            low_a[c] = 0; low_b[c] = 0; bad_a[c] = 0; bad_b[c] = 0;
        end
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            if ((ps_a != (j == 0)) || (ps_b != (j == 0))) ps_bad++;
            for (int c = 0; c < 3; c++) begin
                expb = (j < int'(ea[c])) ? 1'b0 : 1'b1;
                if (led_a[c] != expb) bad_a[c]++;
                if (!led_a[c]) low_a[c]++;
                expb = (j < int'(eb[c])) ? 1'b0 : 1'b1;
                if (led_b[c] != expb) bad_b[c]++;
                if (!led_b[c]) low_b[c]++;
            end
            if (j == chg_at) begin
                mode = cmode;
                duty = cduty;
            end
        end
        check({name, " period_start shape"}, ps_bad, 0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s a ch%0d low count", name, c), low_a[c], int'(ea[c]));
            check($sformatf("%s a ch%0d wrong cycles", name, c), bad_a[c], 0);
            check($sformatf("%s b ch%0d low count", name, c), low_b[c], int'(eb[c]));
            check($sformatf("%s b ch%0d wrong cycles", name, c), bad_b[c], 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t prev;
        exp_t e;
        int   bad;

        vecs[0] = '{mode: 2'd1, duty: {4'd15, 4'd8,  4'd0},  chg_at: 3,  e: mk(0, 8, 15)};
        vecs[1] = '{mode: 2'd1, duty: {4'd15, 4'd3,  4'd0},  chg_at: 4,  e: mk(0, 3, 15)};
        vecs[2] = '{mode: 2'd1, duty: {4'd1,  4'd2,  4'd3},  chg_at: 14, e: mk(3, 2, 1)};
        vecs[3] = '{mode: 2'd0, duty: {4'd15, 4'd15, 4'd15}, chg_at: 0,  e: mk(0, 0, 0)};
        vecs[4] = '{mode: 2'd1, duty: {4'd5,  4'd0,  4'd12}, chg_at: 7,  e: mk(12, 0, 5)};
        vecs[5] = '{mode: 2'd1, duty: {4'd15, 4'd15, 4'd15}, chg_at: 10, e: mk(15, 15, 15)};

        // Reset and first period
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'd1;
        duty  = {4'd15, 4'd8, 4'd0};
        repeat (5) @(negedge clk);
        check("reset led_n a", int'(led_a), 7);
        check("reset led_n b", int'(led_b), 7);
        check("reset period_start", int'({ps_a, ps_b}), 0);
        rst_n = 1'b1;
        wait_first("reset");
        check("first new-duty led_n", int'(led_a), 1);

        // Table vectors: the period in which inputs change keeps the old duty
        prev = mk(0, 8, 15);
        for (int i = 0; i < 6; i++) begin
            run_period($sformatf("vec%0d old", i), 1'b0, prev, prev,
                       vecs[i].chg_at, vecs[i].mode, vecs[i].duty);
            run_period($sformatf("vec%0d new", i), 1'b0, vecs[i].e, vecs[i].e,
                       -1, vecs[i].mode, vecs[i].duty);
            prev = vecs[i].e;
        end

        // Mid-period asynchronous reset while LEDs are lit
        @(negedge clk);
        bad = 0;
        while (!ps_a && bad < 40) begin
            @(negedge clk);
            bad++;
        end
        repeat (2) @(negedge clk);
        check("lit before async reset", int'(led_a[2]), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset led_n a", int'(led_a), 7);
        check("async reset led_n b", int'(led_b), 7);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_first("after async reset");

        // en drop for 3 clk while lit
        repeat (3) @(negedge clk);
        check("lit before en drop", int'(led_a), 0);
        en   = 1'b0;
        mode = 2'd2;
        duty = {4'd10, 4'd10, 4'd10};
        bad  = 0;
        repeat (3) begin
            @(negedge clk);
            if (led_a != 3'b111 || led_b != 3'b111 || ps_a || ps_b) bad++;
        end
        check("en low outputs", bad, 0);
        en = 1'b1;
        wait_first("en resume");

        // BLINK: period k shows seq = k-1
        for (int k = 1; k <= 8; k++) begin
            e = mk((((k-1) >> 0) & 1) != 0 ? 10 : 0,
                   (((k-1) >> 1) & 1) != 0 ? 10 : 0,
                   (((k-1) >> 2) & 1) != 0 ? 10 : 0);
            run_period($sformatf("blink p%0d", k), (k == 1), e, e, -1, mode, duty);
        end

        // BREATHE: period k shows phase = k-1; instance b offset by 8 per channel
        @(negedge clk);
        en   = 1'b0;
        mode = 2'd3;
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_first("breathe start");
        for (int k = 1; k <= 34; k++) begin
            run_period($sformatf("breathe p%0d", k), (k == 1),
                       mk(tri_lvl(k-1), tri_lvl(k-1), tri_lvl(k-1)),
                       mk(tri_lvl(k-1), tri_lvl(k+7), tri_lvl(k+15)),
                       -1, mode, duty);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
